// File: rtl/clock_pkg.sv
// Shared constants for the digital clock chain (minute/hour counters, alarm, display).
package clock_pkg;

    localparam logic [6:0] MIN_MAX     = 7'd59;
    localparam logic [4:0] HOUR_MAX    = 5'd23;
    localparam logic [4:0] NOON        = 5'd12;
    localparam logic [7:0] BCD_INVALID = 8'hFF;

endpackage

// File: rtl/bin2bcd.sv
// Combinational two-digit binary-to-BCD converter; input range 0-99.
module bin2bcd (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] tens_x10;
    logic [3:0] units;

    always_comb begin
        tens = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (bin >= 7'(i * 10)) tens = 4'(i);
        end
    end

    // The remainder is below 10, so modulo-16 arithmetic on the low nibbles is exact.
    assign tens_x10 = tens * 4'd10;
    assign units    = bin[3:0] - tens_x10;
    assign bcd      = {tens, units};

endmodule

// File: rtl/hour_counter.sv
// Hour register of the digital clock: advances on the minute wrap, supports preset,
// and produces 12/24-hour display values with BCD digits and a day-rollover pulse.
module hour_counter
    import clock_pkg::*;
(
    input  logic       seconds,
    input  logic       reset,
    input  logic       set,
    input  logic [4:0] set_hours,
    input  logic       mode_12h,
    input  logic [6:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic       day_tick
);

    logic [6:0] prev_min;
    logic       set_d;
    logic       wrap;
    logic [7:0] minutes_bcd_raw;

    // set_d masks the false 59->0 jump caused by presetting the minute counter.
    assign wrap = (prev_min == MIN_MAX) && (minutes == 7'd0) && !set && !set_d;

    always_ff @(negedge seconds or posedge reset) begin
        if (reset) begin
            hours    <= 5'd0;
            prev_min <= 7'd0;
            set_d    <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            prev_min <= minutes;
            set_d    <= set;
            day_tick <= 1'b0;
            if (set) begin
                if (set_hours <= HOUR_MAX) hours <= set_hours;
            end else if (wrap) begin
                if (hours == HOUR_MAX) begin
                    hours    <= 5'd0;
                    day_tick <= 1'b1;
                end else begin
                    hours <= hours + 5'd1;
                end
            end
        end
    end

    always_comb begin
        disp_hours = hours;
        if (mode_12h) begin
            if (hours == 5'd0)     disp_hours = NOON;
            else if (hours > NOON) disp_hours = hours - NOON;
        end
    end

    assign pm = (hours >= NOON);

    bin2bcd u_hours_bcd (
        .bin ({2'b00, disp_hours}),
        .bcd (hours_bcd)
    );

    bin2bcd u_minutes_bcd (
        .bin (minutes),
        .bcd (minutes_bcd_raw)
    );

    assign minutes_bcd = (minutes > MIN_MAX) ? BCD_INVALID : minutes_bcd_raw;

endmodule
